design_select_sequencer: RTL and testbench

- Controls which student project owns the shared user-area I/O and drives the per-project active-high reset-hold vector (designs_cs) into the reset router.
- On a select request it runs a break-before-make sequence: gate off the I/O mux, hold every project in reset for a programmable time, release only the newly selected project, then re-enable the I/O mux once the router's two-flop synchronizer has settled.
- Sits between the configuration/wishbone register that writes the project number and the reset router/I/O mux.

---
 rtl/design_select_sequencer_if.sv | 24 ++
 rtl/design_select_sequencer.sv | 106 ++++++++++
 tb/tb_design_select_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/design_select_sequencer_if.sv
// Select-request handshake plus the reset-hold / I/O-enable outputs of the project sequencer.
interface design_select_sequencer_if #(
  parameter int NUM_PROJECTS = 13,
  parameter int SELW         = $clog2(NUM_PROJECTS+1)
);
  logic                    req_valid;
  logic [SELW-1:0]         req_sel;
  logic                    req_ready;
  logic                    req_err;
  logic [NUM_PROJECTS:1]   designs_cs;
  logic [SELW-1:0]         active_sel;
  logic                    io_enable;
  logic                    busy;

  modport slave (
    input  req_valid, req_sel,
    output req_ready, req_err, designs_cs, active_sel, io_enable, busy
  );

  modport master (
    output req_valid, req_sel,
    input  req_ready, req_err, designs_cs, active_sel, io_enable, busy
  );
endinterface

// File: rtl/design_select_sequencer.sv
// Break-before-make project switch: isolate I/O, hold all projects in reset,
// release the chosen one, then re-enable I/O after the router synchronizer settles.
module design_select_sequencer #(
  parameter int NUM_PROJECTS = 13,
  parameter int HOLD_CYCLES  = 16,
  parameter int SYNC_CYCLES  = 3,
  parameter int SELW         = $clog2(NUM_PROJECTS+1)
) (
  input  logic                       clk,
  input  logic                       n_rst,
  design_select_sequencer_if.slave   bus
);
  localparam int MAXC = (HOLD_CYCLES > SYNC_CYCLES) ? HOLD_CYCLES : SYNC_CYCLES;
  localparam int CNTW = $clog2(MAXC+1);
  localparam logic [SELW-1:0] MAXID = SELW'(NUM_PROJECTS);

  typedef enum logic [2:0] {S_IDLE, S_ISOLATE, S_HOLD, S_RELEASE, S_SETTLE} state_t;

  state_t                 r_state, w_next;
  logic [CNTW-1:0]        r_cnt;
  logic [SELW-1:0]        r_pend;
  logic [NUM_PROJECTS:1]  r_cs;
  logic [SELW-1:0]        r_act;
  logic                   r_io;
  logic                   r_err;

  logic                   w_accept, w_id_ok, w_hold_done, w_settle_done;
  logic [NUM_PROJECTS:1]  w_rel_mask;

  assign w_accept      = bus.req_valid & (r_state == S_IDLE);
  assign w_id_ok       = (bus.req_sel <= MAXID);
  assign w_hold_done   = (r_cnt == CNTW'(HOLD_CYCLES-1));
  assign w_settle_done = (r_cnt == CNTW'(SYNC_CYCLES-1));

  // Only the pending project's hold bit drops; ID 0 never matches, so all stay held.
  always_comb begin
    w_rel_mask = '1;
    for (int i = 1; i <= NUM_PROJECTS; i++)
      w_rel_mask[i] = (r_pend != SELW'(i));
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept && w_id_ok) w_next = S_ISOLATE;
      S_ISOLATE: w_next = S_HOLD;
      S_HOLD:    if (w_hold_done) w_next = (r_pend == '0) ? S_IDLE : S_RELEASE;
      S_RELEASE: w_next = S_SETTLE;
      S_SETTLE:  if (w_settle_done) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Reset hold is reasserted one cycle after io_enable falls, so the mux is
  // already gated when the previously active project's bit rises.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_cnt  <= '0;
      r_pend <= '0;
      r_cs   <= '1;
      r_act  <= '0;
      r_io   <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_err <= w_accept & ~w_id_ok;
      case (r_state)
        S_IDLE:    if (w_accept && w_id_ok) r_pend <= bus.req_sel;
        S_ISOLATE: begin
          r_io  <= 1'b0;
          r_cnt <= '0;
        end
        S_HOLD: begin
          r_cs  <= '1;
          r_act <= '0;
          r_cnt <= w_hold_done ? '0 : r_cnt + 1'b1;
        end
        S_RELEASE: begin
          r_cs  <= w_rel_mask;
          r_act <= r_pend;
          r_cnt <= '0;
        end
        S_SETTLE: begin
          if (w_settle_done) begin
            r_io  <= 1'b1;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = (r_state == S_IDLE) & n_rst;
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.req_err    = r_err;
  assign bus.designs_cs = r_cs;
  assign bus.active_sel = r_act;
  assign bus.io_enable  = r_io;
endmodule

// File: tb/tb_design_select_sequencer.sv
// Randomized select/deselect traffic against a timeline model of the switch sequence.
module tb_design_select_sequencer;
  localparam int NP = 13;
  localparam int H  = 16;
  localparam int S  = 3;
  localparam logic [12:0] ONES = 13'h1FFF;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  design_select_sequencer_if bus();
  design_select_sequencer dut (.clk(clk), .n_rst(n_rst), .bus(bus));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h exp %0h", tag, got, exp);
  endtask

  // model of the visible state between sequences
  logic [12:0] m_cs  = ONES;
  int          m_act = 0;
  bit          m_io  = 1'b0;

  function automatic logic [12:0] rel(int p);
    logic [12:0] one = 13'h1;
    return ONES & ~(one << (p-1));
  endfunction

  task automatic check_out(string tag, logic [12:0] cs, int act, bit io, bit bsy, bit err);
    chk({tag, "_cs"},    32'(bus.designs_cs), 32'(cs));
    chk({tag, "_act"},   32'(bus.active_sel), 32'(act));
    chk({tag, "_io"},    32'(bus.io_enable),  32'(io));
    chk({tag, "_busy"},  32'(bus.busy),       32'(bsy));
    chk({tag, "_ready"}, 32'(bus.req_ready),  32'(!bsy));
    chk({tag, "_err"},   32'(bus.req_err),    32'(err));
  endtask

  // Structural invariants sampled every cycle
  logic [12:0] prev_cs = ONES;
  logic        prev_io = 1'b0;
  bit          mon_en  = 1'b0;
  always @(negedge clk) begin
    if (mon_en && n_rst) begin
      chk("onehot0", 32'($countones(~bus.designs_cs) <= 1), 32'd1);
      if (bus.designs_cs !== prev_cs)
        chk("io_during_cs_change", {30'd0, prev_io, bus.io_enable}, 32'd0);
    end
    prev_cs = bus.designs_cs;
    prev_io = bus.io_enable;
  end

  // Present a request at a negedge; returns at the negedge after the accept edge.
  task automatic present(int sel);
    int w = 0;
    while (!bus.req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) chk("ready_timeout", 32'd0, 32'd1);
    bus.req_valid = 1'b1;
    bus.req_sel   = sel[3:0];
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // k = number of edges after the accept edge at which the sample is taken
  task automatic do_req(int p, int inj);
    present(p);
    if (p > NP) begin
      check_out("inv_k0", m_cs, m_act, m_io, 1'b0, 1'b1);
      @(negedge clk);
      check_out("inv_k1", m_cs, m_act, m_io, 1'b0, 1'b0);
      return;
    end
    for (int k = 0; k <= H + S + 3; k++) begin
      logic [12:0] ecs;
      int          eact;
      bit          eio, ebusy;
      if (k < 2)            begin ecs = m_cs; eact = m_act; end
      else if (k <= H + 1)  begin ecs = ONES; eact = 0;     end
      else if (p == 0)      begin ecs = ONES; eact = 0;     end
      else                  begin ecs = rel(p); eact = p;   end
      eio   = (k < 1) ? m_io : (p != 0 && k >= H + S + 2);
      ebusy = (p == 0) ? (k <= H) : (k <= H + S + 1);
      if (k > 0) @(negedge clk);
      if (bus.req_valid) bus.req_valid = 1'b0;
      check_out($sformatf("sel%0d_k%0d", p, k), ecs, eact, eio, ebusy, 1'b0);
      if (k == inj) begin
        bus.req_valid = 1'b1;
        bus.req_sel   = 4'($urandom_range(0, 15));
      end
    end
    m_cs  = (p == 0) ? ONES : rel(p);
    m_act = p;
    m_io  = (p != 0);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_sel   = '0;
    repeat (2) @(negedge clk);
    chk("rst_cs",    32'(bus.designs_cs), 32'(ONES));
    chk("rst_io",    32'(bus.io_enable),  32'd0);
    chk("rst_ready", 32'(bus.req_ready),  32'd0);
    n_rst = 1'b1;
    #1;
    check_out("rst_rel", ONES, 0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    mon_en = 1'b1;

    do_req(5, -1);
    do_req(9, 3);
    do_req(0, -1);
    do_req(14, -1);
    do_req(9, 5);
    do_req(9, -1);

    for (int t = 0; t < 30; t++) begin
      int p = $urandom_range(0, 15);
      int inj = ($urandom_range(0, 1) == 1) ? $urandom_range(2, H - 2) : -1;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_req(p, inj);
    end

    // Asynchronous reset during SETTLE of a select-3 sequence
    present(3);
    repeat (H + 3) @(negedge clk);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    chk("mid_io",   32'(bus.io_enable), 32'd0);
    #2 n_rst = 1'b0;
    #1;
    chk("mid_rst_cs",    32'(bus.designs_cs), 32'(ONES));
    chk("mid_rst_act",   32'(bus.active_sel), 32'd0);
    chk("mid_rst_io",    32'(bus.io_enable),  32'd0);
    chk("mid_rst_busy",  32'(bus.busy),       32'd0);
    chk("mid_rst_ready", 32'(bus.req_ready),  32'd0);
    @(negedge clk);
    n_rst = 1'b1;
    #1;
    check_out("mid_rel", ONES, 0, 1'b0, 1'b0, 1'b0);
    m_cs = ONES; m_act = 0; m_io = 1'b0;
    @(negedge clk);
    do_req(7, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running exp finished");
    $fatal(1);
  end
endmodule
